cntr8_cmd_seq: RTL and testbench
================================

Name: cntr8_cmd_seq

Overview:
- Command sequencer directly upstream of the 8-bit load/increment counter; produces that counter's inc, load and d_in inputs.
- Accepts opcode+argument commands over a valid/ready handshake and expands each into a cycle-exact pulse train: load pulse, N increment cycles, or N idle cycles.
- Lets software/test logic drive the counter with bulk commands instead of per-cycle strobes.

Parameters:
- DATA_W, 8, width of cmd_arg, d_in and internal remaining-count register.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present on cmd_op/cmd_arg
- cmd_ready  output  1  sequencer can accept a command this cycle
- cmd_op  input  2  00 NOP, 01 LOAD, 10 STEP, 11 WAIT
- cmd_arg  input  DATA_W  LOAD value, or cycle count for STEP/WAIT
- inc  output  1  to counter inc
- load  output  1  to counter load
- d_in  output  DATA_W  to counter d_in
- busy  output  1  command in progress (or queued)
- cmd_done  output  1  one-cycle pulse per completed command

Behaviour:
- Clock and reset: one clock, clk; reset_n asynchronous, active-low. Asserting reset_n=0 immediately forces inc=0, load=0, d_in=0, cmd_done=0, busy=0, cmd_ready=1 and state=IDLE, and flushes any queue.
- All outputs are registered except cmd_ready, which is decoded from state (and from queue fill when the optional feature is compiled in).
- Handshake: a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1. Without the queue, cmd_ready=1 only in IDLE. cmd_op/cmd_arg are sampled only at acceptance.
- FSM states: IDLE, LOAD, STEP, WAIT. A remaining-count register rem has width DATA_W.
- IDLE: inc=0, load=0.
  - Accept LOAD -> next state LOAD.
  - Accept STEP or WAIT with arg>=1 -> next state STEP or WAIT, with rem=arg.
  - Accept NOP, or STEP/WAIT with arg=0 -> stay in IDLE; cmd_done=1 for the next cycle; no inc/load activity.
- LOAD: lasts exactly one cycle, in the cycle immediately after the accepting edge; load=1, d_in=arg. Then go to IDLE.
- STEP: inc=1 for exactly arg consecutive cycles, starting the cycle after acceptance. rem decrements each cycle; leave for IDLE when rem==1.
- WAIT: identical timing to STEP but inc=0. It occupies the sequencer so following commands are delayed by arg cycles.
- load and inc are never asserted in the same cycle.
- d_in holds the last LOAD argument between loads; it is 0 after reset.
- cmd_done: high for one cycle, in the cycle following the last active cycle of a command (first IDLE cycle).
- busy: high while state!=IDLE or a queue entry is pending.
- Without the queue, back-to-back commands are separated by one IDLE cycle.
- Count width: arg=255 (DATA_W=8) gives 255 inc cycles; there is no wrap inside the sequencer. Counter overflow is the downstream block's concern.
- Reset during STEP/WAIT/LOAD: the operation is aborted; cmd_done is not pulsed; no residual inc after reset release.

Optional Feature:
- Macro: CNTR8_CMD_QUEUE_EN.
- Defined: a 2-entry command FIFO sits in front of the FSM.
  - cmd_ready = FIFO not full, independent of FSM state.
  - The FSM pops on any edge where it is IDLE or in the last active cycle (LOAD, or rem==1). Consecutive commands therefore produce adjacent pulse trains with no gap.
  - Latency from acceptance to first active cycle is 2 cycles if the FSM is idle.
  - Zero-count/NOP commands are popped and pulse cmd_done without a gap cycle.
- Undefined: no FIFO; behaviour exactly as above; 1-cycle latency.

Test Plan:
- Reset: hold reset_n=0 with cmd_valid=1, LOAD 44 -> inc=0, load=0, d_in=0, busy=0, cmd_ready=1; nothing accepted. Release -> IDLE.
- LOAD 44 -> load=1 with d_in=44 for exactly one cycle; cmd_done one cycle later; attached counter d_out=44.
- STEP 5 from counter value 0 -> inc=1 for exactly 5 consecutive cycles; cmd_ready=0 throughout; cmd_done next cycle; counter reads 5.
- NOP, STEP 0, WAIT 3 -> no inc/load at any time; cmd_done one cycle after each zero-length command; WAIT 3 keeps busy=1 for 3 cycles.
- STEP 10, reset_n=0 after 3 inc cycles -> inc drops asynchronously; no cmd_done; after release, no further inc; counter reads 0.
- With CNTR8_CMD_QUEUE_EN: present LOAD 44, STEP 3, STEP 2, WAIT 4 on consecutive cycles.
  - Required response: one load cycle, then 5 adjacent inc cycles (counter reads 49), then 4 idle busy cycles.
  - cmd_ready drops when the FIFO is full; a held cmd_valid is accepted later.

Source files
------------

// File: rtl/cntr8_cmd_seq.sv
// Command sequencer feeding the 8-bit load/increment counter: expands LOAD/STEP/WAIT commands into pulse trains.
// Optional 2-entry command FIFO in front of the FSM when CNTR8_CMD_QUEUE_EN is defined (adjacent pulse trains, 2-cycle latency).
module cntr8_cmd_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  output logic              inc,
  output logic              load,
  output logic [DATA_W-1:0] d_in,
  output logic              busy,
  output logic              cmd_done
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_WAIT} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_rem;
  logic                r_inc;
  logic                r_load;
  logic [DATA_W-1:0]   r_d_in;
  logic                r_busy;
  logic                r_done;

  logic                w_active;
  logic                w_last;
  logic                w_start;
  logic [1:0]          w_op;
  logic [DATA_W-1:0]   w_arg;
  logic                w_q_pend;
  logic                w_start_active;
  logic                w_busy_nxt;

  assign w_active = (r_state != S_IDLE);
  assign w_last   = (r_state == S_LOAD) ||
                    (((r_state == S_STEP) || (r_state == S_WAIT)) && (r_rem == DATA_W'(1)));

`ifdef CNTR8_CMD_QUEUE_EN
  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] arg;
  } cmd_t;

  cmd_t       r_q [2];
  logic [1:0] r_q_cnt;
  logic       w_push;
  logic       w_idx;
  logic [1:0] w_q_cnt_nxt;

  assign cmd_ready   = (r_q_cnt != 2'd2);
  assign w_push      = cmd_valid && cmd_ready;
  // Pop in the last active cycle so the next pulse train starts with no gap.
  assign w_start     = (!w_active || w_last) && (r_q_cnt != 2'd0);
  assign w_op        = r_q[0].op;
  assign w_arg       = r_q[0].arg;
  assign w_idx       = r_q_cnt[0] && !w_start;
  assign w_q_cnt_nxt = r_q_cnt + {1'b0, w_push} - {1'b0, w_start};
  assign w_q_pend    = (w_q_cnt_nxt != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_cnt <= 2'd0;
      r_q[0]  <= '0;
      r_q[1]  <= '0;
    end else begin
      r_q_cnt <= w_q_cnt_nxt;
      if (w_start) r_q[0] <= r_q[1];
      if (w_push)  r_q[w_idx] <= '{op: cmd_op, arg: cmd_arg};
    end
  end
`else
  assign cmd_ready = (r_state == S_IDLE);
  assign w_start   = cmd_valid && cmd_ready;
  assign w_op      = cmd_op;
  assign w_arg     = cmd_arg;
  assign w_q_pend  = 1'b0;
`endif

  assign w_start_active = w_start &&
                          ((w_op == OP_LOAD) || (w_op[1] && (w_arg != '0)));
  assign w_busy_nxt     = (w_active && !w_last) || w_start_active || w_q_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_inc   <= 1'b0;
      r_load  <= 1'b0;
      r_d_in  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      r_busy <= w_busy_nxt;
      if (w_active && w_last) begin
        r_state <= S_IDLE;
        r_inc   <= 1'b0;
        r_done  <= 1'b1;
      end else if (w_active) begin
        r_rem <= r_rem - DATA_W'(1);
      end
      if (w_start) begin
        r_inc <= 1'b0;
        case (w_op)
          OP_LOAD: begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
            r_d_in  <= w_arg;
          end
          OP_STEP, OP_WAIT: begin
            if (w_arg != '0) begin
              r_state <= (w_op == OP_STEP) ? S_STEP : S_WAIT;
              r_rem   <= w_arg;
              r_inc   <= (w_op == OP_STEP);
            end else begin
              r_done <= 1'b1;
            end
          end
          OP_NOP:  r_done <= 1'b1;
          default: r_done <= 1'b1;
        endcase
      end
    end
  end

  assign inc      = r_inc;
  assign load     = r_load;
  assign d_in     = r_d_in;
  assign busy     = r_busy;
  assign cmd_done = r_done;

endmodule

// File: tb/tb_cntr8_cmd_seq.sv
// Directed bench for cntr8_cmd_seq: a monitor turns load pulses, inc bursts and cmd_done into events
// that are matched against expectations queued when each command is driven.
module tb_cntr8_cmd_seq;

  localparam int DATA_W = 8;
`ifdef CNTR8_CMD_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif
  // cmd_ready while a command runs: FIFO has room in queue builds, FSM busy otherwise.
  localparam logic RDY_ACT = QUEUE;

  localparam logic [7:0] EV_LOAD = 8'd1;
  localparam logic [7:0] EV_INC  = 8'd2;
  localparam logic [7:0] EV_DONE = 8'd3;

  logic              clk;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_arg;
  logic              inc;
  logic              load;
  logic [DATA_W-1:0] d_in;
  logic              busy;
  logic              cmd_done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          burst = 0;
  logic [7:0]  cnt;

  cntr8_cmd_seq #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .inc(inc), .load(load), .d_in(d_in),
    .busy(busy), .cmd_done(cmd_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Attached downstream counter.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= 8'd0;
    else if (load) cnt <= d_in;
    else if (inc)  cnt <= cnt + 8'd1;
  end

  function automatic logic [31:0] ev(input logic [7:0] kind, input int val);
    return {kind, val[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [31:0] e);
    logic [31:0] x;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_unexpected: observed=%0h expected=none", e);
    end
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk("sb_event", e, x);
    end
  endtask

  always @(negedge clk) begin
    if (load && inc) chk("load_and_inc", 32'd1, 32'd0);
    if (load) emit(ev(EV_LOAD, int'(d_in)));
    if (inc) burst++;
    else if (burst != 0) begin
      emit(ev(EV_INC, burst));
      burst = 0;
    end
    if (cmd_done) emit(ev(EV_DONE, 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 100 && !cmd_ready; n++) step();
    chk("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Returns sampled in the first active cycle of the command.
  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    wait_ready();
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    if (QUEUE) step();
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = 8'd44;
    repeat (3) step();
    chk("rst_inc", 32'(inc), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_d_in", 32'(d_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(cmd_done), 32'd0);
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    repeat (3) step();
    chk("post_rst_d_in", 32'(d_in), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // LOAD 44
    exp_q.push_back(ev(EV_LOAD, 44));
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b01, 8'd44);
    chk("ld_load", 32'(load), 32'd1);
    chk("ld_d_in", 32'(d_in), 32'd44);
    chk("ld_busy", 32'(busy), 32'd1);
    chk("ld_ready", 32'(cmd_ready), 32'(RDY_ACT));
    step();
    chk("ld_load_off", 32'(load), 32'd0);
    chk("ld_done", 32'(cmd_done), 32'd1);
    chk("ld_busy_off", 32'(busy), 32'd0);
    chk("ld_cnt", 32'(cnt), 32'd44);
    chk("ld_d_in_hold", 32'(d_in), 32'd44);

    // LOAD 0 then STEP 5
    exp_q.push_back(ev(EV_LOAD, 0));
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b01, 8'd0);
    step();
    exp_q.push_back(ev(EV_INC, 5));
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b10, 8'd5);
    for (int i = 0; i < 5; i++) begin
      chk("st5_inc", 32'(inc), 32'd1);
      chk("st5_ready", 32'(cmd_ready), 32'(RDY_ACT));
      step();
    end
    chk("st5_inc_off", 32'(inc), 32'd0);
    chk("st5_done", 32'(cmd_done), 32'd1);
    chk("st5_cnt", 32'(cnt), 32'd5);

    // Zero-length commands
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b00, 8'd7);
    chk("nop_done", 32'(cmd_done), 32'd1);
    chk("nop_busy", 32'(busy), 32'd0);
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b10, 8'd0);
    chk("st0_done", 32'(cmd_done), 32'd1);
    chk("st0_inc", 32'(inc), 32'd0);
    chk("st0_busy", 32'(busy), 32'd0);

    // WAIT 3
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b11, 8'd3);
    for (int i = 0; i < 3; i++) begin
      chk("wt3_busy", 32'(busy), 32'd1);
      chk("wt3_inc", 32'(inc), 32'd0);
      chk("wt3_done", 32'(cmd_done), 32'd0);
      step();
    end
    chk("wt3_done_end", 32'(cmd_done), 32'd1);
    chk("wt3_busy_end", 32'(busy), 32'd0);
    chk("wt3_cnt", 32'(cnt), 32'd5);

    // Full-range STEP 255 from 0
    exp_q.push_back(ev(EV_LOAD, 0));
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b01, 8'd0);
    step();
    exp_q.push_back(ev(EV_INC, 255));
    exp_q.push_back(ev(EV_DONE, 0));
    send(2'b10, 8'd255);
    repeat (255) step();
    chk("st255_done", 32'(cmd_done), 32'd1);
    chk("st255_cnt", 32'(cnt), 32'd255);

    // STEP 10 aborted by reset after 3 inc cycles
    step();
    exp_q.push_back(ev(EV_INC, 3));
    send(2'b10, 8'd10);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    chk("abort_inc", 32'(inc), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_inc", 32'(inc), 32'd0);
      chk("abort_no_done", 32'(cmd_done), 32'd0);
    end
    chk("abort_cnt", 32'(cnt), 32'd0);

`ifdef CNTR8_CMD_QUEUE_EN
    // Consecutive commands through the FIFO
    exp_q.push_back(ev(EV_LOAD, 44));
    exp_q.push_back(ev(EV_DONE, 0));
    exp_q.push_back(ev(EV_DONE, 0));
    exp_q.push_back(ev(EV_INC, 5));
    exp_q.push_back(ev(EV_DONE, 0));
    exp_q.push_back(ev(EV_DONE, 0));
    exp_q.push_back(ev(EV_DONE, 0));
    cmd_valid = 1'b1;
    cmd_op = 2'b01; cmd_arg = 8'd44;
    step();
    cmd_op = 2'b10; cmd_arg = 8'd3;
    step();
    chk("q_load", 32'(load), 32'd1);
    cmd_op = 2'b10; cmd_arg = 8'd2;
    step();
    chk("q_inc", 32'(inc), 32'd1);
    cmd_op = 2'b11; cmd_arg = 8'd4;
    step();
    cmd_op = 2'b11; cmd_arg = 8'd1;
    chk("q_full_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("q_full_ready2", 32'(cmd_ready), 32'd0);
    wait_ready();
    step();
    cmd_valid = 1'b0;
    for (int n = 0; n < 40 && busy; n++) step();
    chk("q_idle_timeout", 32'(busy), 32'd0);
    repeat (3) step();
    chk("q_cnt", 32'(cnt), 32'd49);
`endif

    repeat (3) step();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
